instruction_sequencer: RTL

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer_pkg.sv | 37 +++
 rtl/instruction_sequencer_program_store.sv | 24 ++
 rtl/instruction_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, instruction field
// positions, FSM state encoding and the read-after-write hazard rule.
package instruction_sequencer_pkg;

  localparam int INSTR_W = 17;
  localparam int ADDR_W  = 5;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_TERN = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;

  localparam int OP_HI  = 16;
  localparam int OP_LO  = 15;
  localparam int WA_HI  = 14;
  localparam int WA_LO  = 10;
  localparam int RA1_HI = 9;
  localparam int RA1_LO = 5;
  localparam int RA2_HI = 4;
  localparam int RA2_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Stores neither write a register nor depend on one written just before.
  function automatic logic raw_hazard(input logic [INSTR_W-1:0] cur,
                                      input logic [INSTR_W-1:0] nxt);
    return (cur[OP_HI:OP_LO] != OP_SW) && (nxt[OP_HI:OP_LO] != OP_SW) &&
           ((nxt[RA1_HI:RA1_LO] == cur[WA_HI:WA_LO]) ||
            (nxt[RA2_HI:RA2_LO] == cur[WA_HI:WA_LO]));
  endfunction

endpackage

// File: rtl/instruction_sequencer_program_store.sv
// Program store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a program survives a reset.
module program_store
  import instruction_sequencer_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic               clock,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// Issues a stored program word by word to a two-register datapath, holding each
// word for a fixed number of clocks and stretching it on read-after-write hazards.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int DEPTH         = 32,
  parameter int HOLD_CYCLES   = 2,
  parameter int HAZARD_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load_en,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [INSTR_W-1:0]  load_data,
  input  logic [5:0]          prog_len,
  input  logic                start,
  input  logic                abort,
  output logic [INSTR_W-1:0]  instruction,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  // instr_valid qualifies instruction and pc on every clock it is high; there is
  // no ready, the datapath takes each word for as long as it is presented.

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  pc_nx;
  logic [7:0]         hold_cnt, hold_cnt_nx;
  logic [5:0]         len_q, len_nx;
  logic [INSTR_W-1:0] instr_q, instr_nx;
  logic [INSTR_W-1:0] rd_data;
  logic [ADDR_W-1:0]  rd_addr;
  logic [5:0]         pc_inc;
  logic [5:0]         len_sat;
  logic [7:0]         hold_limit;
  logic               hazard;

  assign busy    = (state == ISSUE) || (state == HOLD);
  assign pc_inc  = {1'b0, pc} + 6'd1;
  assign len_sat = (prog_len > 6'(DEPTH)) ? 6'(DEPTH) : prog_len;

  // During HOLD the read port looks ahead at the next word for hazard checking.
  assign rd_addr    = (state == HOLD) ? pc_inc[ADDR_W-1:0] : pc;
  assign hazard     = (pc_inc < len_q) && raw_hazard(instr_q, rd_data);
  assign hold_limit = 8'(HOLD_CYCLES) + (hazard ? 8'(HAZARD_CYCLES) : 8'd0);

  program_store #(.DEPTH(DEPTH)) u_store (
    .clock (clock),
    .we    (load_en && !busy),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= '0;
      hold_cnt <= '0;
      len_q    <= '0;
      instr_q  <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      hold_cnt <= hold_cnt_nx;
      len_q    <= len_nx;
      instr_q  <= instr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    hold_cnt_nx = hold_cnt;
    len_nx      = len_q;
    instr_nx    = instr_q;
    case (state)
      IDLE: begin
        if (start && (prog_len != 6'd0)) begin
          state_nx    = ISSUE;
          pc_nx       = '0;
          len_nx      = len_sat;
          hold_cnt_nx = '0;
        end
      end
      ISSUE: begin
        instr_nx    = rd_data;
        hold_cnt_nx = 8'd1;
        state_nx    = HOLD;
      end
      HOLD: begin
        // The ISSUE clock counts as the first clock of the hold.
        if (hold_cnt + 8'd1 >= hold_limit) begin
          hold_cnt_nx = '0;
          if (pc_inc < len_q) begin
            pc_nx    = pc_inc[ADDR_W-1:0];
            state_nx = ISSUE;
          end else begin
            state_nx = DONE;
          end
        end else begin
          hold_cnt_nx = hold_cnt + 8'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx    = IDLE;
      hold_cnt_nx = '0;
    end
  end

  always_comb begin
    instruction = '0;
    if (state == ISSUE)     instruction = rd_data;
    else if (state == HOLD) instruction = instr_q;
  end

  assign instr_valid = busy;
  assign done        = (state == DONE);
  assign state_dbg   = state;

endmodule
